lsu_buf: RTL

LSU_BUF -- requirements
Module: lsu_buf

---
 rtl/lsu_buf.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_buf.sv
// Load/store buffer: request FIFO feeding a single-outstanding data-bus FSM with load writeback.
// Optional LSU_MISALIGN_CHK_EN adds misaligned-access trapping (misalign / misalign_addr ports).
module lsu_buf #(
    parameter int XLEN       = 32,
    parameter int MEMB_PARA  = 9,
    parameter int MEMB_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_vld,
    input  logic [MEMB_PARA-1:0] mem_para,
    input  logic [XLEN-1:0]      mem_addr,
    input  logic [XLEN-1:0]      mem_wdata,
    output logic                 mem_rdy,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    output logic [3:0]           dmem_be,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvld,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 wb_vld,
    output logic [4:0]           wb_sel,
    output logic [XLEN-1:0]      wb_data,
    output logic                 busy
`ifdef LSU_MISALIGN_CHK_EN
    ,
    output logic                 misalign,
    output logic [XLEN-1:0]      misalign_addr
`endif
);
    localparam int AW = $clog2(MEMB_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [MEMB_PARA-1:0] para_mem  [MEMB_DEPTH];
    logic [XLEN-1:0]      addr_mem  [MEMB_DEPTH];
    logic [XLEN-1:0]      wdata_mem [MEMB_DEPTH];

    // Extra MSB on each pointer separates full from empty when the index bits match.
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop, load_done, misalign_hit;
    logic [1:0]  state, state_nxt;

    logic [MEMB_PARA-1:0] h_para;
    logic [XLEN-1:0]      h_addr, h_wdata;
    logic                 h_store;
    logic [1:0]           h_size;
    logic [4:0]           h_rd;
    logic [3:0]           lane_be;
    logic [XLEN-1:0]      lane_wdata, byte_sh, half_sh, load_data;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign mem_rdy = ~full;
    assign push    = mem_vld & ~full;
    assign busy    = ~empty | (state != S_IDLE);

    assign h_para  = para_mem[rd_ptr[AW-1:0]];
    assign h_addr  = addr_mem[rd_ptr[AW-1:0]];
    assign h_wdata = wdata_mem[rd_ptr[AW-1:0]];
    assign h_store = h_para[0];
    assign h_size  = h_para[2:1];
    assign h_rd    = h_para[8:4];

`ifdef LSU_MISALIGN_CHK_EN
    assign misalign_hit = (h_size == 2'b01 && h_addr[0]) || (h_size[1] && h_addr[1:0] != 2'b00);
`else
    assign misalign_hit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = h_wdata;
        if (h_size == 2'b00) begin
            lane_be    = 4'b0001 << h_addr[1:0];
            lane_wdata = {(XLEN/8){h_wdata[7:0]}};
        end else if (h_size == 2'b01) begin
            lane_be    = 4'b0011 << {h_addr[1], 1'b0};
            lane_wdata = {(XLEN/16){h_wdata[15:0]}};
        end
    end

    assign byte_sh = dmem_rdata >> {h_addr[1:0], 3'b000};
    assign half_sh = dmem_rdata >> {h_addr[1], 4'b0000};

    // funct3[2] selects zero extension; any size code with bit 1 set is a full word.
    always_comb begin
        load_data = dmem_rdata;
        if (h_size == 2'b00) begin
            load_data = h_para[3] ? {{(XLEN-8){1'b0}}, byte_sh[7:0]}
                                  : {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
        end else if (h_size == 2'b01) begin
            load_data = h_para[3] ? {{(XLEN-16){1'b0}}, half_sh[15:0]}
                                  : {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
        end
    end

    assign dmem_req   = (state == S_REQ);
    assign dmem_we    = dmem_req & h_store;
    assign dmem_addr  = dmem_req ? {h_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? lane_be : 4'b0000;
    assign dmem_wdata = dmem_we ? lane_wdata : '0;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    if (misalign_hit) pop = 1'b1;
                    else              state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    if (h_store) begin
                        pop       = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvld) begin
                    pop       = 1'b1;
                    load_done = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: entry storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            para_mem[wr_ptr[AW-1:0]]  <= mem_para;
            addr_mem[wr_ptr[AW-1:0]]  <= mem_addr;
            wdata_mem[wr_ptr[AW-1:0]] <= mem_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state   <= S_IDLE;
            wb_vld  <= 1'b0;
            wb_sel  <= 5'd0;
            wb_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            state  <= state_nxt;
            wb_vld <= load_done && (h_rd != 5'd0);
            if (load_done) begin
                wb_sel  <= h_rd;
                wb_data <= load_data;
            end
        end
    end

`ifdef LSU_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign <= (state == S_IDLE) && !empty && misalign_hit;
            if ((state == S_IDLE) && !empty && misalign_hit) misalign_addr <= h_addr;
        end
    end
`endif

endmodule
